// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // Index counter width; a single-nibble adder still keeps a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    n = nibble_count(width);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum of products; no ripple between bit positions.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder reusing one 4-bit CLA slice with a registered carry chain.
// Optional subtract mode is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = nibble_count(WIDTH);
  localparam int unsigned IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e r_state;
  state_e w_state_next;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_sum;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_carry;
  logic                             r_cout;
  logic                             r_ovf;

  logic                w_accept;
  logic                w_last;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_carry_init;
  logic [NIBBLE_W-1:0] w_slice_a;
  logic [NIBBLE_W-1:0] w_slice_b;
  logic [NIBBLE_W-1:0] w_slice_s;
  logic                w_slice_co;
  logic                w_a_msb;
  logic                w_b_msb;
  logic                w_ovf;

`ifdef CLA_SEQ_SUB_EN
  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  assign w_b_eff      = sub ? ~b : b;
  assign w_carry_init = sub | cin;
`else
  assign w_b_eff      = b;
  assign w_carry_init = cin;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_idx == LAST_IDX);

  assign w_slice_a = r_a[r_idx];
  assign w_slice_b = r_b[r_idx];

  cla4_slice u_slice (
    .a  (w_slice_a),
    .b  (w_slice_b),
    .ci (r_carry),
    .s  (w_slice_s),
    .co (w_slice_co)
  );

  // On the last nibble the slice output is the result MSB nibble.
  assign w_a_msb = r_a[NIBBLES-1][NIBBLE_W-1];
  assign w_b_msb = r_b[NIBBLES-1][NIBBLE_W-1];
  assign w_ovf   = (w_a_msb == w_b_msb) & (w_slice_s[NIBBLE_W-1] != w_a_msb);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode, from state registers only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_carry_init;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx] <= w_slice_s;
          r_carry      <= w_slice_co;
          if (w_last) begin
            r_cout <= w_slice_co;
            r_ovf  <= w_ovf;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  // A stalled result must not change until the sink takes it.
  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout) && $stable(ovf)));

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed table, reset/backpressure sequences,
// randomized back-to-back traffic against an arithmetic model, plus a WIDTH=4 instance.
module tb_cla_seq_adder;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  cla_seq_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .ovf       (ovf4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    bit          sub;
    logic [15:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  typedef struct {
    longint s;
    bit     co;
    bit     ov;
  } res_t;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input int unsigned w, input longint ua, input longint ub,
                                 input bit c, input bit s);
    res_t   r;
    longint m, sa, sb, ur, sr;
    m  = longint'(1) << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      ur   = ua - ub;
      sr   = sa - sb;
      r.co = (ua >= ub);
    end else begin
      ur   = ua + ub + longint'(c);
      sr   = sa + sb + longint'(c);
      r.co = (ur >= m);
    end
    r.s  = ((ur % m) + m) % m;
    r.ov = (sr >= m / 2) || (sr < -(m / 2));
    return r;
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input bit tc,
                        input bit ts, output logic [15:0] rs, output bit rc, output bit ro,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_ack", in_ready, 1);
    check("out_valid_after_ack", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [15:0] rs;
    bit          rc, ro;
    int          lat, seen, bad;

    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'h0FF0, 16'h0010, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});
`ifdef CLA_SEQ_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif
    // Leaves cout=1 in IDLE so the reset sequence below observes it clear.
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro, lat);
      check($sformatf("tbl%0d_latency", i), lat, 4);
      check($sformatf("tbl%0d_sum", i), rs, tbl[i].s);
      check($sformatf("tbl%0d_cout", i), rc, tbl[i].co);
      check($sformatf("tbl%0d_ovf", i), ro, tbl[i].ov);
      release_result();
    end

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrun_rst_no_result", seen, 0);

    // Backpressure: result held while sink stalls, new operands ignored
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, ro, lat);
    check("bp_latency", lat, 4);
    check("bp_sum", rs, 16'h5555);
    bad = 0;
    a = 16'hAAAA; b = 16'h5555; cin = 1; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || sum != 16'h5555 || cout != 1'b0 || ovf != 1'b0) bad++;
    end
    in_valid = 1'b0;
    check("bp_stable_cycles_bad", bad, 0);
    release_result();

    // Back-to-back random traffic with out_ready held high
    begin
      logic [15:0] pa[8], pb[8];
      bit          pc[8], ps[8];
      res_t        expq[$];
      res_t        e;
      int          acc[$];
      int          k, cyc, got;
      for (int i = 0; i < 8; i++) begin
        pa[i] = 16'($urandom);
        pb[i] = 16'($urandom);
        pc[i] = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
        ps[i] = 1'($urandom);
`else
        ps[i] = 1'b0;
`endif
      end
      k = 0; cyc = 0; got = 0;
      out_ready = 1'b1;
      @(negedge clk);
      a = pa[0]; b = pb[0]; cin = pc[0]; sub = ps[0]; in_valid = 1'b1;
      while (got < 8 && cyc < 200) begin
        if (out_valid) begin
          if (expq.size() == 0) begin
            check("b2b_unexpected_result", 1, 0);
          end else begin
            e = expq.pop_front();
            check($sformatf("b2b%0d_sum", got), sum, e.s);
            check($sformatf("b2b%0d_cout", got), cout, e.co);
            check($sformatf("b2b%0d_ovf", got), ovf, e.ov);
          end
          got++;
        end
        if (in_ready && in_valid) begin
          expq.push_back(model(16, longint'(a), longint'(b), cin, sub));
          acc.push_back(cyc);
          k++;
        end
        @(negedge clk);
        cyc++;
        if (k < 8) begin
          a = pa[k]; b = pb[k]; cin = pc[k]; sub = ps[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("b2b_results", got, 8);
      check("b2b_accepts", acc.size(), 8);
      for (int i = 1; i < acc.size(); i++)
        check($sformatf("b2b_interval%0d", i), acc[i] - acc[i-1], 6);
    end

    // WIDTH=4: single-nibble adder, one-edge latency
    for (int i = 0; i < 8; i++) begin
      res_t e4;
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'b0;
      if (i == 0) begin
        a4 = 4'h7; b4 = 4'h0; cin4 = 1'b1;
      end
      e4 = model(4, longint'(a4), longint'(b4), cin4, 1'b0);
      in_valid4 = 1'b1;
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      check($sformatf("w4_%0d_not_yet_valid", i), out_valid4, 0);
      @(posedge clk);
      #1;
      check($sformatf("w4_%0d_latency1", i), out_valid4, 1);
      check($sformatf("w4_%0d_sum", i), sum4, e4.s);
      check($sformatf("w4_%0d_cout", i), cout4, e4.co);
      check($sformatf("w4_%0d_ovf", i), ovf4, e4.ov);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
      check($sformatf("w4_%0d_in_ready", i), in_ready4, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Nibble-serial WIDTH-bit adder/subtractor controller that reuses a single 4-bit carry-lookahead slice over WIDTH/4 cycles, chaining the carry through a register. It sits between a valid/ready operand source and a valid/ready result sink. It trades throughput for area where a full-width CLA is not justified.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b, cin (and sub) valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  1 = A − B (present only with CLA_SEQ_SUB_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB nibble.
- ovf  out  1  signed two's-complement overflow.

## Operation
- FSM: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch a, b_eff (b, or ~b when subtracting) and carry register (cin, or 1 when subtracting);
  - clear nibble index idx and sum;
  - go to RUN.
- RUN: each cycle the slice adds a[4*idx+:4] + b_eff[4*idx+:4] + carry.
  - Slice result is written to sum[4*idx+:4]; slice carry goes to the carry register; idx increments.
  - When idx = WIDTH/4−1: go to DONE and write cout = slice carry and ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
- DONE: out_valid=1, with sum/cout/ovf stable. On out_ready, go to IDLE.
- sum/cout/ovf hold their last value in IDLE until the next accept clears sum.
- in_ready=0 in RUN and DONE. Inputs are ignored there.
- idx width is clog2(WIDTH/4), minimum 1. idx never wraps past WIDTH/4−1.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry (no-borrow flag in subtract mode).

## Timing
- Reset value of every output: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. State goes to IDLE, idx=0, carry=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation and discards the result. No out_valid pulse.
- Latency: out_valid rises WIDTH/4 edges after the accept edge (4 for WIDTH=16; 1 for WIDTH=4).
- Throughput: one operation per WIDTH/4+2 cycles when out_ready is held high (accept, WIDTH/4 RUN edges, DONE→IDLE edge).
- The sink may stall indefinitely. out_valid and the result stay stable until out_ready.
- out_valid&out_ready and in_valid are never combined in one cycle; there is no same-cycle re-accept from DONE.
- No combinational path exists from in_valid or out_ready to any output. in_ready and out_valid are decoded from state registers.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - sub port exists;
  - sub=1 latches b_eff=~b and initial carry=1, and cin is ignored;
  - sub=0 behaves as plain add.
- CLA_SEQ_SUB_EN undefined:
  - no sub port;
  - b_eff=b and initial carry=cin always;
  - no inversion logic.

## Structure
- Shared package cla_pkg:
  - state typedef (IDLE, RUN, DONE);
  - NIBBLE_W=4 constant;
  - the nibble-count function (WIDTH/4).
- One sub-module, cla4_slice: purely combinational 4-bit generate/propagate lookahead adder with ports a[3:0], b[3:0], ci → s[3:0], co. It is instantiated once.
- The controller holds the FSM, idx counter, carry register, operand registers and result register.

## Test plan
- Reset: assert rst mid-RUN on a 0xFFFF+0x0001 add → in_ready=1, out_valid=0, sum=0 immediately; no result is emitted after release.
- Carry ripple: WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → out_valid 4 edges after accept, sum=0x0000, cout=1, ovf=0.
- Overflow and carry-in: a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Subtract (CLA_SEQ_SUB_EN): a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0 throughout; with out_ready=1, in_ready returns the next cycle.
- Back-to-back: in_valid held high with 8 random operand pairs and out_ready=1 → one accept every 6 cycles (WIDTH=16); every result matches a reference model; also run WIDTH=4 with 1-edge latency.
